mac_share_arbiter: RTL

- Shares one 16x16 multiply-accumulate unit (RESULT = A*B +/- ACCUM, iCE40 DSP configured as in the misc peripheral) between NREQ requesters, e.g. the CPU-facing misc register file and a hardware LED-fade engine.
- Round-robin arbitration with a valid/ready handshake. Issues at most one operation per cycle to the MAC operand latches.
- Tracks the owner of each in-flight operation through a fixed-latency pipeline and routes the result back to that owner only.

---
 rtl/mac_share_pkg.sv | 15 +
 rtl/rr_grant.sv | 29 ++
 rtl/mac_share_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mac_share_pkg.sv
// mac_share_pkg: shared constants, id-width helper and in-flight tag type for the MAC arbiter.
package mac_share_pkg;
    localparam int MAC_OP_W = 16;
    localparam int MAC_DW   = 32;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // id is sized for the largest legal NREQ (4)
    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin one-hot grant; search starts after i_ptr,
// or at i_ptr itself when i_hold keeps the current owner in front.
module rr_grant
    import mac_share_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_hold,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    int w_start;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_start = i_hold ? int'(i_ptr) : (int'(i_ptr) + 1) % N;
        // walk from lowest to highest priority so the first valid candidate wins
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(w_start + k) % N]) begin
                o_gnt = N'(1) << ((w_start + k) % N);
                o_idx = IW'((w_start + k) % N);
            end
        end
    end
endmodule

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one 16x16 MAC between NREQ requesters with result routing.
// Optional burst lock via macro MAC_SHARE_ARBITER_LOCK_EN.
module mac_share_arbiter
    import mac_share_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LAT   = 1,
    parameter int AW_OP = MAC_OP_W,
    parameter int DW    = MAC_DW
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_reset_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*AW_OP-1:0] req_op_a_i,
    input  logic [NREQ*AW_OP-1:0] req_op_b_i,
    input  logic [NREQ*DW-1:0]   req_accum_i,
    input  logic [NREQ-1:0]      req_sub_i,
    input  logic [NREQ-1:0]      req_lock_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]        rsp_result_o,
    output logic                 rsp_carry_o,
    output logic                 mac_issue_o,
    output logic [AW_OP-1:0]     mac_a_o,
    output logic [AW_OP-1:0]     mac_b_o,
    output logic [DW-1:0]        mac_accum_o,
    output logic                 mac_sub_o,
    input  logic [DW-1:0]        mac_result_i,
    input  logic                 mac_carry_i,
    output logic                 busy_o
);
    localparam int IW = id_width(NREQ);

    if (NREQ < 2 || NREQ > 4 || LAT < 1 || LAT > 3) begin : g_bad_param
        $error("mac_share_arbiter: NREQ must be 2..4 and LAT 1..3");
    end

    logic [NREQ-1:0]  w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_hs;
    logic             w_hold;
    logic             w_busy;
    logic [IW-1:0]    r_ptr;
    logic             r_issue;
    logic [AW_OP-1:0] r_a;
    logic [AW_OP-1:0] r_b;
    logic [DW-1:0]    r_acc;
    logic             r_sub;
    tag_t             r_tag [LAT];
    logic [NREQ-1:0]  r_rsp_v;
    logic [DW-1:0]    r_res;
    logic             r_carry;

`ifdef MAC_SHARE_ARBITER_LOCK_EN
    logic r_lock;
    assign w_hold = r_lock & req_valid_i[r_ptr];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock_i;
    assign w_hold        = 1'b0;
`endif

    rr_grant #(.N(NREQ), .IW(IW)) u_rr_grant (
        .i_req  (req_valid_i),
        .i_ptr  (r_ptr),
        .i_hold (w_hold),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    // no grant is offered while the block is held in reset
    assign req_ready_o = w_gnt & {NREQ{wb_reset_n_i}};
    assign w_hs        = |req_valid_i;

    always_comb begin
        w_busy = r_issue;
        for (int t = 0; t < LAT; t++) w_busy = w_busy | r_tag[t].valid;
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            r_ptr   <= IW'(NREQ - 1);
            r_issue <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sub   <= 1'b0;
            for (int t = 0; t < LAT; t++) r_tag[t] <= '0;
            r_rsp_v <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
`ifdef MAC_SHARE_ARBITER_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            r_issue <= w_hs;
            if (w_hs) begin
                r_ptr <= w_idx;
                r_a   <= req_op_a_i[w_idx*AW_OP +: AW_OP];
                r_b   <= req_op_b_i[w_idx*AW_OP +: AW_OP];
                r_acc <= req_accum_i[w_idx*DW +: DW];
                r_sub <= req_sub_i[w_idx];
            end
            r_tag[0] <= '{valid: w_hs, id: 2'(w_idx)};
            for (int t = 1; t < LAT; t++) r_tag[t] <= r_tag[t-1];
            r_rsp_v <= r_tag[LAT-1].valid ? NREQ'(1) << r_tag[LAT-1].id : '0;
            if (r_tag[LAT-1].valid) begin
                r_res   <= mac_result_i;
                r_carry <= mac_carry_i;
            end
`ifdef MAC_SHARE_ARBITER_LOCK_EN
            r_lock <= w_hs ? req_lock_i[w_idx] : w_hold;
`endif
        end
    end

    assign mac_issue_o  = r_issue;
    assign mac_a_o      = r_a;
    assign mac_b_o      = r_b;
    assign mac_accum_o  = r_acc;
    assign mac_sub_o    = r_sub;
    assign rsp_valid_o  = r_rsp_v;
    assign rsp_result_o = r_res;
    assign rsp_carry_o  = r_carry;
    assign busy_o       = w_busy;
endmodule
